// File: rtl/sipo_reader.sv
// AXI4-Lite master that configures the sipo block, polls its status and drains
// its read port onto a valid/ready stream.
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 32
`endif
`ifndef AXI4_STRB_BITS
`define AXI4_STRB_BITS 4
`endif
`ifndef AXI4_PROT_BITS
`define AXI4_PROT_BITS 3
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif
`ifndef AXI4_RESP_OKAY
`define AXI4_RESP_OKAY 2'b00
`endif

// state       | meaning
// ST_IDLE     | disabled, no traffic
// ST_CFG_AW   | ctrl write address/data in flight
// ST_CFG_B    | waiting for ctrl write response
// ST_POLL_AR  | status read address
// ST_POLL_R   | status read data
// ST_DATA_AR  | data (pop) read address
// ST_DATA_R   | data (pop) read data
// ST_HOLD     | popped word presented on out_*
// ST_WAIT     | idle interval between empty polls
module sipo_reader #(
    parameter logic [`AXI4_ADDR_BITS-1:0] BASE_ADDR = '0,
    parameter int POLL_INTERVAL = 16,
    parameter int OUT_WIDTH     = 32,
    parameter int CNT_BITS      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,

    output logic                        m_axi4lite_aw_valid,
    input  logic                        m_axi4lite_aw_ready,
    output logic [`AXI4_ADDR_BITS-1:0]  m_axi4lite_aw_addr,
    output logic [`AXI4_PROT_BITS-1:0]  m_axi4lite_aw_prot,

    output logic                        m_axi4lite_w_valid,
    input  logic                        m_axi4lite_w_ready,
    output logic [`AXI4_DATA_BITS-1:0]  m_axi4lite_w_data,
    output logic [`AXI4_STRB_BITS-1:0]  m_axi4lite_w_strb,

    input  logic                        m_axi4lite_b_valid,
    output logic                        m_axi4lite_b_ready,
    input  logic [`AXI4_RESP_BITS-1:0]  m_axi4lite_b_resp,

    output logic                        m_axi4lite_ar_valid,
    input  logic                        m_axi4lite_ar_ready,
    output logic [`AXI4_ADDR_BITS-1:0]  m_axi4lite_ar_addr,
    output logic [`AXI4_PROT_BITS-1:0]  m_axi4lite_ar_prot,

    input  logic                        m_axi4lite_r_valid,
    output logic                        m_axi4lite_r_ready,
    input  logic [`AXI4_DATA_BITS-1:0]  m_axi4lite_r_data,
    input  logic [`AXI4_RESP_BITS-1:0]  m_axi4lite_r_resp,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic                        err,
    output logic [CNT_BITS-1:0]         word_cnt
);

    localparam int WAIT_BITS = $clog2(POLL_INTERVAL + 1);
    localparam logic [WAIT_BITS-1:0] WAIT_LOAD = WAIT_BITS'(POLL_INTERVAL - 1);
    localparam logic [`AXI4_ADDR_BITS-1:0] ADDR_DATA = BASE_ADDR;
    localparam logic [`AXI4_ADDR_BITS-1:0] ADDR_STAT = BASE_ADDR + `AXI4_ADDR_BITS'(8);
    localparam logic [`AXI4_ADDR_BITS-1:0] ADDR_CTRL = BASE_ADDR + `AXI4_ADDR_BITS'(16);
    // ctrl: bit0 en, bit1 user_rstn
    localparam logic [`AXI4_DATA_BITS-1:0] CFG_WORD = `AXI4_DATA_BITS'(3);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_AW,
        ST_CFG_B,
        ST_POLL_AR,
        ST_POLL_R,
        ST_DATA_AR,
        ST_DATA_R,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t               state;
    logic [WAIT_BITS-1:0] wait_cnt;

    assign m_axi4lite_aw_prot = '0;
    assign m_axi4lite_ar_prot = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            wait_cnt            <= '0;
            m_axi4lite_aw_valid <= 1'b0;
            m_axi4lite_aw_addr  <= '0;
            m_axi4lite_w_valid  <= 1'b0;
            m_axi4lite_w_data   <= '0;
            m_axi4lite_w_strb   <= '0;
            m_axi4lite_b_ready  <= 1'b0;
            m_axi4lite_ar_valid <= 1'b0;
            m_axi4lite_ar_addr  <= '0;
            m_axi4lite_r_ready  <= 1'b0;
            out_valid           <= 1'b0;
            out_data            <= '0;
            err                 <= 1'b0;
            word_cnt            <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state               <= ST_CFG_AW;
                        m_axi4lite_aw_valid <= 1'b1;
                        m_axi4lite_aw_addr  <= ADDR_CTRL;
                        m_axi4lite_w_valid  <= 1'b1;
                        m_axi4lite_w_data   <= CFG_WORD;
                        m_axi4lite_w_strb   <= '1;
                    end
                end
                ST_CFG_AW: begin
                    if (m_axi4lite_aw_ready) m_axi4lite_aw_valid <= 1'b0;
                    if (m_axi4lite_w_ready)  m_axi4lite_w_valid  <= 1'b0;
                    if ((!m_axi4lite_aw_valid || m_axi4lite_aw_ready) &&
                        (!m_axi4lite_w_valid  || m_axi4lite_w_ready)) begin
                        state              <= ST_CFG_B;
                        m_axi4lite_b_ready <= 1'b1;
                    end
                end
                ST_CFG_B: begin
                    if (m_axi4lite_b_valid) begin
                        m_axi4lite_b_ready  <= 1'b0;
                        if (m_axi4lite_b_resp != `AXI4_RESP_OKAY) err <= 1'b1;
                        state               <= ST_POLL_AR;
                        m_axi4lite_ar_valid <= 1'b1;
                        m_axi4lite_ar_addr  <= ADDR_STAT;
                    end
                end
                ST_POLL_AR: begin
                    if (m_axi4lite_ar_ready) begin
                        m_axi4lite_ar_valid <= 1'b0;
                        m_axi4lite_r_ready  <= 1'b1;
                        state               <= ST_POLL_R;
                    end
                end
                ST_POLL_R: begin
                    if (m_axi4lite_r_valid) begin
                        m_axi4lite_r_ready <= 1'b0;
                        if (m_axi4lite_r_resp != `AXI4_RESP_OKAY || m_axi4lite_r_data[0]) begin
                            if (m_axi4lite_r_resp != `AXI4_RESP_OKAY) err <= 1'b1;
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state               <= ST_DATA_AR;
                            m_axi4lite_ar_valid <= 1'b1;
                            m_axi4lite_ar_addr  <= ADDR_DATA;
                        end
                    end
                end
                ST_DATA_AR: begin
                    if (m_axi4lite_ar_ready) begin
                        m_axi4lite_ar_valid <= 1'b0;
                        m_axi4lite_r_ready  <= 1'b1;
                        state               <= ST_DATA_R;
                    end
                end
                ST_DATA_R: begin
                    if (m_axi4lite_r_valid) begin
                        m_axi4lite_r_ready <= 1'b0;
                        if (m_axi4lite_r_resp != `AXI4_RESP_OKAY) begin
                            // popped word is corrupt; drop it rather than deliver
                            err      <= 1'b1;
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            out_data  <= m_axi4lite_r_data[OUT_WIDTH-1:0];
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        word_cnt  <= word_cnt + CNT_BITS'(1);
                        if (enable) begin
                            state               <= ST_POLL_AR;
                            m_axi4lite_ar_valid <= 1'b1;
                            m_axi4lite_ar_addr  <= ADDR_STAT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == '0) begin
                        state               <= ST_POLL_AR;
                        m_axi4lite_ar_valid <= 1'b1;
                        m_axi4lite_ar_addr  <= ADDR_STAT;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_BITS'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_reader.sv
// Directed bench for sipo_reader with a behavioural sipo AXI4-Lite slave.
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 32
`endif
`ifndef AXI4_STRB_BITS
`define AXI4_STRB_BITS 4
`endif
`ifndef AXI4_PROT_BITS
`define AXI4_PROT_BITS 3
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif
`ifndef AXI4_RESP_OKAY
`define AXI4_RESP_OKAY 2'b00
`endif

module tb_sipo_reader;
    localparam int PI = 5;
    localparam int CB = 2;

    logic clk = 0, rst = 1, enable = 0;
    logic aw_valid, aw_ready = 1, w_valid, w_ready = 1, b_valid, b_ready;
    logic ar_valid, ar_ready = 1, r_valid, r_ready, out_valid, out_ready = 1, err;
    logic [31:0] aw_addr, ar_addr, w_data, r_data, out_data;
    logic [3:0]  w_strb;
    logic [2:0]  aw_prot, ar_prot;
    logic [1:0]  b_resp, r_resp;
    logic [CB-1:0] word_cnt;

    sipo_reader #(.BASE_ADDR(32'h0), .POLL_INTERVAL(PI), .OUT_WIDTH(32), .CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .m_axi4lite_aw_valid(aw_valid), .m_axi4lite_aw_ready(aw_ready),
        .m_axi4lite_aw_addr(aw_addr), .m_axi4lite_aw_prot(aw_prot),
        .m_axi4lite_w_valid(w_valid), .m_axi4lite_w_ready(w_ready),
        .m_axi4lite_w_data(w_data), .m_axi4lite_w_strb(w_strb),
        .m_axi4lite_b_valid(b_valid), .m_axi4lite_b_ready(b_ready), .m_axi4lite_b_resp(b_resp),
        .m_axi4lite_ar_valid(ar_valid), .m_axi4lite_ar_ready(ar_ready),
        .m_axi4lite_ar_addr(ar_addr), .m_axi4lite_ar_prot(ar_prot),
        .m_axi4lite_r_valid(r_valid), .m_axi4lite_r_ready(r_ready),
        .m_axi4lite_r_data(r_data), .m_axi4lite_r_resp(r_resp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // sipo slave model and event log
    logic [31:0] q[$];
    logic [31:0] got[$];
    logic [1:0]  cfg_resp = 2'b00, data_resp = 2'b00;
    logic aw_seen = 0, w_seen = 0, rd_is_stat = 0;
    int cyc = 0, wr_count = 0, ar8_cnt = 0, stat_hs_cnt = 0, data_reads = 0, bad_pop = 0;
    int last_ar8_cyc = 0, last_stat_cyc = 0, out_hs_cyc = 0;
    int tests_run = 0, tests_failed = 0;

    initial begin
        b_valid = 0; b_resp = 0; r_valid = 0; r_resp = 0; r_data = 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ar_valid && ar_addr == 32'h0 && out_valid) bad_pop <= bad_pop + 1;
        if (out_valid && out_ready) begin
            got.push_back(out_data);
            out_hs_cyc <= cyc;
        end
        if (rst) begin
            b_valid <= 0; r_valid <= 0; aw_seen <= 0; w_seen <= 0;
            q.delete();
        end else begin
            if (aw_valid && aw_ready) aw_seen <= 1;
            if (w_valid && w_ready) w_seen <= 1;
            if (b_valid && b_ready) begin
                b_valid  <= 0;
                wr_count <= wr_count + 1;
            end else if (!b_valid && aw_seen && w_seen) begin
                b_valid <= 1; b_resp <= cfg_resp; aw_seen <= 0; w_seen <= 0;
            end
            if (r_valid && r_ready) begin
                r_valid <= 0;
                if (rd_is_stat) begin
                    stat_hs_cnt   <= stat_hs_cnt + 1;
                    last_stat_cyc <= cyc;
                end
            end else if (!r_valid && ar_valid && ar_ready) begin
                r_valid    <= 1;
                rd_is_stat <= (ar_addr == 32'h8);
                if (ar_addr == 32'h8) begin
                    r_data       <= (q.size() == 0) ? 32'hA5A5_0001 : 32'hA5A5_0000;
                    r_resp       <= 2'b00;
                    ar8_cnt      <= ar8_cnt + 1;
                    last_ar8_cyc <= cyc;
                end else begin
                    r_data     <= (q.size() != 0) ? q.pop_front() : 32'hBAD0BAD0;
                    r_resp     <= data_resp;
                    data_reads <= data_reads + 1;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1; enable = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({aw_valid, w_valid, b_ready, ar_valid, r_ready} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_valids: got %b expected 00000", {aw_valid, w_valid, b_ready, ar_valid, r_ready});
        end
        tests_run++;
        if ({out_valid, err, word_cnt, out_data} !== '0) begin
            tests_failed++; $display("FAIL reset_out: out_valid=%b err=%b cnt=%0d data=%h expected all 0", out_valid, err, word_cnt, out_data);
        end
        tests_run++;
        if ({aw_prot, ar_prot} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_prot: got %b expected 000000", {aw_prot, ar_prot});
        end
    endtask

    task automatic test_cfg();
        bit found = 0;
        rst = 0; enable = 1;
        @(posedge clk); #1;
        tests_run++;
        if ({aw_valid, w_valid, aw_addr, w_data, w_strb} !== {2'b11, 32'h10, 32'h3, 4'hf}) begin
            tests_failed++; $display("FAIL cfg_write: aw_v=%b w_v=%b addr=%h data=%h strb=%h expected 1 1 10 3 f", aw_valid, w_valid, aw_addr, w_data, w_strb);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ar_valid && ar_addr == 32'h8) found = 1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++; $display("FAIL cfg_to_poll: status read never issued, expected ar at 0x08");
        end
        tests_run++;
        if (err !== 1'b0 || wr_count !== 1) begin
            tests_failed++; $display("FAIL cfg_err: err=%b writes=%0d expected err 0 writes 1", err, wr_count);
        end
    endtask

    task automatic test_empty_poll();
        int s0 = stat_hs_cnt, a0;
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (stat_hs_cnt > s0) found = 1;
        end
        a0 = ar8_cnt;
        for (int i = 0; i < 30 && found && ar8_cnt == a0; i++) @(negedge clk);
        tests_run++;
        if (!found || ar8_cnt == a0) begin
            tests_failed++; $display("FAIL empty_repoll: status poll timed out, expected repoll");
        end
        // ar_valid rises PI cycles after the status r handshake; address handshakes one edge later
        tests_run++;
        if (last_ar8_cyc - last_stat_cyc !== PI + 1) begin
            tests_failed++; $display("FAIL poll_interval: got %0d expected %0d", last_ar8_cyc - last_stat_cyc, PI + 1);
        end
        tests_run++;
        if (data_reads !== 0) begin
            tests_failed++; $display("FAIL empty_no_pop: data reads %0d expected 0", data_reads);
        end
    endtask

    task automatic test_single_word();
        got.delete();
        out_ready = 1;
        q.push_back(32'hDEADBEEF);
        for (int i = 0; i < 60 && got.size() == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        tests_run++;
        if (got.size() != 1 || got[0] !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL single_word: got %0d words first=%h expected 1 deadbeef", got.size(), (got.size() != 0) ? got[0] : 32'h0);
        end
        tests_run++;
        if (word_cnt !== 2'd1) begin
            tests_failed++; $display("FAIL single_cnt: got %0d expected 1", word_cnt);
        end
        tests_run++;
        if (last_ar8_cyc - out_hs_cyc !== 1) begin
            tests_failed++; $display("FAIL immediate_repoll: gap %0d expected 1", last_ar8_cyc - out_hs_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w[3] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3};
        int d0 = data_reads;
        got.delete();
        out_ready = 0;
        for (int i = 0; i < 3; i++) q.push_back(exp_w[i]);
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== exp_w[0]) begin
            tests_failed++; $display("FAIL hold_stable: valid=%b data=%h expected 1 %h", out_valid, out_data, exp_w[0]);
        end
        tests_run++;
        if (data_reads !== d0 + 1 || bad_pop !== 0) begin
            tests_failed++; $display("FAIL hold_no_pop: pops=%0d bad=%0d expected %0d 0", data_reads - d0, bad_pop, 1);
        end
        out_ready = 1;
        for (int i = 0; i < 100 && got.size() < 3; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (got.size() <= i || got[i] !== exp_w[i]) begin
                tests_failed++; $display("FAIL order_%0d: got %h expected %h", i, (got.size() > i) ? got[i] : 32'h0, exp_w[i]);
            end
        end
        tests_run++;
        if (word_cnt !== 2'd0 || bad_pop !== 0) begin
            tests_failed++; $display("FAIL cnt_wrap: cnt=%0d bad=%0d expected 0 0", word_cnt, bad_pop);
        end
    endtask

    task automatic test_errors();
        int w0, d0;
        rst = 1; enable = 0;
        repeat (2) @(negedge clk);
        cfg_resp = 2'b10; data_resp = 2'b10;
        got.delete();
        w0 = wr_count;
        rst = 0; enable = 1;
        for (int i = 0; i < 20 && wr_count == w0; i++) @(negedge clk);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++; $display("FAIL cfg_slverr: err=%b expected 1", err);
        end
        d0 = data_reads;
        q.push_back(32'h11111111);
        for (int i = 0; i < 60 && data_reads == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        tests_run++;
        if (data_reads == d0 || out_valid !== 1'b0 || got.size() != 0) begin
            tests_failed++; $display("FAIL data_slverr: pops=%0d out_valid=%b delivered=%0d expected 1 0 0", data_reads - d0, out_valid, got.size());
        end
        data_resp = 2'b00; cfg_resp = 2'b00;
        q.push_back(32'h22222222);
        for (int i = 0; i < 60 && got.size() == 0; i++) @(negedge clk);
        tests_run++;
        if (got.size() != 1 || got[0] !== 32'h22222222 || word_cnt !== 2'd1) begin
            tests_failed++; $display("FAIL after_err_word: n=%0d cnt=%0d expected 1 word 22222222 cnt 1", got.size(), word_cnt);
        end
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++; $display("FAIL err_sticky: err=%b expected 1", err);
        end
    endtask

    task automatic test_disable();
        int a8, w0;
        bit found = 0;
        got.delete();
        out_ready = 1;
        q.push_back(32'h33333333);
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (ar_valid && ar_addr == 32'h0) found = 1;
        end
        @(negedge clk);
        enable = 0;
        for (int i = 0; i < 10 && got.size() == 0; i++) @(negedge clk);
        tests_run++;
        if (!found || got.size() != 1 || got[0] !== 32'h33333333) begin
            tests_failed++; $display("FAIL disable_deliver: found=%b n=%0d expected word 33333333", found, got.size());
        end
        a8 = ar8_cnt; w0 = wr_count;
        repeat (10) @(negedge clk);
        tests_run++;
        if (ar8_cnt !== a8 || ar_valid !== 1'b0 || aw_valid !== 1'b0 || wr_count !== w0) begin
            tests_failed++; $display("FAIL disable_idle: polls=%0d writes=%0d ar_v=%b expected 0 0 0", ar8_cnt - a8, wr_count - w0, ar_valid);
        end
        enable = 1;
        for (int i = 0; i < 20 && wr_count == w0; i++) @(negedge clk);
        tests_run++;
        if (wr_count !== w0 + 1) begin
            tests_failed++; $display("FAIL reenable_cfg: writes=%0d expected 1", wr_count - w0);
        end
        ar_ready = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ar_valid) found = 1;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (!found || ar_valid !== 1'b1 || ar_addr !== 32'h8) begin
            tests_failed++; $display("FAIL ar_hold: ar_v=%b addr=%h expected 1 8", ar_valid, ar_addr);
        end
        rst = 1;
        @(posedge clk); #1;
        tests_run++;
        if ({ar_valid, aw_valid, w_valid, r_ready, b_ready, out_valid, err, word_cnt} !== '0) begin
            tests_failed++; $display("FAIL rst_mid_ar: ar_v=%b r_rdy=%b out_v=%b err=%b cnt=%0d expected all 0", ar_valid, r_ready, out_valid, err, word_cnt);
        end
        rst = 0; enable = 0; ar_ready = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_empty_poll();
        test_single_word();
        test_back_to_back();
        test_errors();
        test_disable();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
